icb2apb_brg: RTL
================

ICB2APB_BRG -- requirements
Module: icb2apb_brg

Interface
- REQ-001 SHALL have parameter AW, default 32, address width of the ICB command and APB paddr.
- REQ-002 SHALL have parameter DW, default 32, data width of ICB and APB; pstrb width is DW/8.
- REQ-003 SHALL have parameter USR_W, default 1, width of the user sideband returned with the response.
- REQ-004 SHALL have parameter TIMEOUT, default 16, number of ACCESS cycles before abort; used only when the timeout feature is compiled in.
- REQ-005 SHALL have port clk, input, 1, single clock for all logic.
- REQ-006 SHALL have port rst, input, 1, reset that is synchronous and active-low.
- REQ-007 SHALL have port i_icb_cmd_vld, input, 1, command valid.
- REQ-008 SHALL have port i_icb_cmd_rdy, output, 1, command ready.
- REQ-009 SHALL have port i_icb_cmd_read, input, 1, 1 = read and 0 = write.
- REQ-010 SHALL have port i_icb_cmd_addr, input, AW, byte address.
- REQ-011 SHALL have port i_icb_cmd_wdata, input, DW, write data.
- REQ-012 SHALL have port i_icb_cmd_wmask, input, DW/8, byte enables.
- REQ-013 SHALL have port i_icb_cmd_usr, input, USR_W, user tag.
- REQ-014 SHALL have ports i_icb_rsp_vld (output, 1) and i_icb_rsp_rdy (input, 1), the response handshake.
- REQ-015 SHALL have ports i_icb_rsp_err (output, 1), i_icb_rsp_rdata (output, DW) and i_icb_rsp_usr (output, USR_W), the response payload.
- REQ-016 SHALL have APB outputs o_apb_psel (1), o_apb_penable (1), o_apb_pwrite (1), o_apb_paddr (AW), o_apb_pwdata (DW) and o_apb_pstrb (DW/8).
- REQ-017 SHALL have APB inputs o_apb_pready (1), o_apb_prdata (DW) and o_apb_pslverr (1).

Function
- REQ-018 SHALL implement an FSM with states IDLE, SETUP, ACCESS and RSP; the reset state is IDLE.
- REQ-019 SHALL drive i_icb_cmd_rdy = 1 only in IDLE, combinationally and independent of i_icb_cmd_vld.
- REQ-020 SHALL, on a command handshake in cycle N, register read, addr, wdata, wmask and usr, and enter SETUP in cycle N+1.
- REQ-021 SHALL, in SETUP, drive psel=1 and penable=0, and enter ACCESS the next cycle unconditionally.
- REQ-022 SHALL, in ACCESS, drive psel=1 and penable=1; when pready=1 is sampled, capture prdata (reads only; writes capture 0) and pslverr, then enter RSP.
- REQ-023 SHALL drive pwrite = ~read, pstrb = wmask for writes and 0 for reads, and hold paddr, pwdata, pwrite and pstrb stable from SETUP through the end of ACCESS.
- REQ-024 SHALL drive psel=0 and penable=0 in IDLE and RSP.
- REQ-025 SHALL assert i_icb_rsp_vld only in RSP, with err, rdata and usr held stable until i_icb_rsp_rdy=1.
- REQ-026 SHALL return to IDLE in the cycle after the response handshake.
- REQ-027 SHALL give a minimum latency of 3 cycles from command handshake to rsp_vld (pready=1 on the first ACCESS cycle), and a minimum of 4 cycles between back-to-back command handshakes.
- REQ-028 SHALL ignore pready and pslverr outside ACCESS.
- REQ-029 SHALL keep at most one transfer outstanding; no pipelining or bypass.
- REQ-030 SHALL, on i_icb_rsp_rdy=0 in RSP, hold indefinitely with no APB activity.

Reset
- REQ-031 SHALL, when rst=0 at a clk edge, force state IDLE and set psel, penable, pwrite, paddr, pwdata, pstrb, rsp_vld, rsp_err, rsp_rdata, rsp_usr and the timeout counter to 0.
- REQ-032 SHALL treat reset asserted mid-transfer (SETUP, ACCESS or RSP) as an abandoned transfer: psel is low the cycle after reset and no response is produced.
- REQ-033 SHALL drive i_icb_cmd_rdy=0 while rst=0.

Configuration
- REQ-034 SHALL, with macro ICB2APB_TIMEOUT_EN defined, count consecutive ACCESS cycles with pready=0; when the count reaches TIMEOUT, deassert psel/penable and enter RSP with err=1 and rdata=0.
- REQ-035 SHALL clear the timeout counter on entry to SETUP.
- REQ-036 SHALL, if pready=1 arrives on the same cycle the count reaches TIMEOUT, complete the transfer normally with no timeout.
- REQ-037 SHALL, without ICB2APB_TIMEOUT_EN, omit the counter, wait indefinitely in ACCESS, and derive err solely from pslverr.

Verification
- REQ-038 SHALL verify a single write: addr=0x40, wdata=0xDEADBEEF, wmask=0xF, pready high at the first ACCESS -> psel at N+1, penable at N+2, pstrb=0xF, rsp_vld at N+3 with err=0.
- REQ-039 SHALL verify a read with 3 wait states: prdata=0x12345678 at pready -> rsp_rdata=0x12345678, rsp_usr equals cmd usr, and rsp_vld 6 cycles after the handshake.
- REQ-040 SHALL verify pslverr=1 on a write -> rsp_err=1, and rsp_rdata=0.
- REQ-041 SHALL verify rsp_rdy held low 5 cycles -> rsp_vld and payload stable, cmd_rdy=0, and psel=0 throughout.
- REQ-042 SHALL verify, with ICB2APB_TIMEOUT_EN and TIMEOUT=16, pready stuck low -> psel falls after 16 ACCESS cycles and rsp err=1, rdata=0; with pready=1 on the 16th cycle -> err=0.
- REQ-043 SHALL verify rst=0 asserted during ACCESS -> psel=0 on the next cycle, no rsp_vld, and cmd_rdy=1 on the first cycle after rst=1.

Source files
------------

// File: rtl/icb2apb_brg.sv
// ICB to APB bridge: one outstanding ICB command becomes one APB
// SETUP/ACCESS transfer, then an ICB response is returned.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   i_icb_cmd_*         ICB command channel (vld/rdy, read, addr,
//                       wdata, wmask, usr)
//   i_icb_rsp_*         ICB response channel (vld/rdy, err, rdata, usr)
//   o_apb_psel..pstrb   APB requester outputs
//   o_apb_pready,
//   o_apb_prdata,
//   o_apb_pslverr       APB completer inputs
//
// Optional macro ICB2APB_TIMEOUT_EN: abort an ACCESS phase after
// TIMEOUT cycles with pready low, answering with err=1, rdata=0.
module icb2apb_brg #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int USR_W   = 1,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_icb_cmd_vld,
  output logic              i_icb_cmd_rdy,
  input  logic              i_icb_cmd_read,
  input  logic [AW-1:0]     i_icb_cmd_addr,
  input  logic [DW-1:0]     i_icb_cmd_wdata,
  input  logic [DW/8-1:0]   i_icb_cmd_wmask,
  input  logic [USR_W-1:0]  i_icb_cmd_usr,
  output logic              i_icb_rsp_vld,
  input  logic              i_icb_rsp_rdy,
  output logic              i_icb_rsp_err,
  output logic [DW-1:0]     i_icb_rsp_rdata,
  output logic [USR_W-1:0]  i_icb_rsp_usr,
  output logic              o_apb_psel,
  output logic              o_apb_penable,
  output logic              o_apb_pwrite,
  output logic [AW-1:0]     o_apb_paddr,
  output logic [DW-1:0]     o_apb_pwdata,
  output logic [DW/8-1:0]   o_apb_pstrb,
  input  logic              o_apb_pready,
  input  logic [DW-1:0]     o_apb_prdata,
  input  logic              o_apb_pslverr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RSP
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [USR_W-1:0] r_usr;
  logic [USR_W-1:0] r_rsp_usr;
  logic [DW-1:0]    r_rsp_rdata;
  logic             r_rsp_err;
  logic             r_pwrite;
  logic [AW-1:0]    r_paddr;
  logic [DW-1:0]    r_pwdata;
  logic [DW/8-1:0]  r_pstrb;

  logic w_cmd_hs;
  logic w_done;
  logic w_tout;

  assign i_icb_cmd_rdy = (r_state == S_IDLE) & rst;
  assign w_cmd_hs      = i_icb_cmd_rdy & i_icb_cmd_vld;
  assign w_done        = (r_state == S_ACCESS) & o_apb_pready;

`ifdef ICB2APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_to_cnt;

  // A pready arriving on the last allowed cycle wins over the abort.
  assign w_tout = (r_state == S_ACCESS) & ~o_apb_pready
                & (r_to_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if (w_cmd_hs) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !o_apb_pready
                 && !w_tout) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_tout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_cmd_hs) w_nxt = S_SETUP;
      end
      S_SETUP: begin
        w_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (w_done || w_tout) w_nxt = S_RSP;
      end
      S_RSP: begin
        if (i_icb_rsp_rdy) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Command fields are latched once and stay put until the next
  // command, which keeps the APB payload stable across SETUP/ACCESS.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
      r_usr    <= '0;
    end else if (w_cmd_hs) begin
      r_pwrite <= ~i_icb_cmd_read;
      r_paddr  <= i_icb_cmd_addr;
      r_pwdata <= i_icb_cmd_wdata;
      r_pstrb  <= i_icb_cmd_read ? '0 : i_icb_cmd_wmask;
      r_usr    <= i_icb_cmd_usr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_usr   <= '0;
    end else if (w_done) begin
      r_rsp_err   <= o_apb_pslverr;
      r_rsp_rdata <= r_pwrite ? '0 : o_apb_prdata;
      r_rsp_usr   <= r_usr;
    end else if (w_tout) begin
      r_rsp_err   <= 1'b1;
      r_rsp_rdata <= '0;
      r_rsp_usr   <= r_usr;
    end
  end

  assign o_apb_psel    = (r_state == S_SETUP) | (r_state == S_ACCESS);
  assign o_apb_penable = (r_state == S_ACCESS);
  assign o_apb_pwrite  = r_pwrite;
  assign o_apb_paddr   = r_paddr;
  assign o_apb_pwdata  = r_pwdata;
  assign o_apb_pstrb   = r_pstrb;

  assign i_icb_rsp_vld   = (r_state == S_RSP);
  assign i_icb_rsp_err   = r_rsp_err;
  assign i_icb_rsp_rdata = r_rsp_rdata;
  assign i_icb_rsp_usr   = r_rsp_usr;

endmodule
